// File: rtl/rv_multicycle_ctrl.sv
// Control FSM for the RV32I multicycle datapath: fetch, decode, execute, memory, writeback.
// Traps on unsupported opcodes and on memory handshakes that exceed MEM_TIMEOUT wait cycles.
module rv_multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode_i,
   input  logic             branch_taken_i,
   input  logic             mem_ready_i,
   output logic             imem_req_o,
   output logic             ir_we_o,
   output logic             pc_we_o,
   output logic             pc_sel_o,
   output logic             dmem_req_o,
   output logic             dmem_we_o,
   output logic             reg_write_o,
   output logic [1:0]       wb_sel_o,
   output logic             alu_src_o,
   output logic [1:0]       alu_op_o,
   output logic [1:0]       fault_o,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] instret_o
);

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_TRAP   = 3'd5;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   logic [2:0]       state_q, state_d;
   logic [6:0]       op_q, op_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic [1:0]       fault_q, fault_d;
   logic [CNT_W-1:0] instret_q;
   logic             opcode_legal;

   assign state_o   = state_q;
   assign fault_o   = fault_q;
   assign instret_o = instret_q;

   always_comb begin
      case (opcode_i)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL: opcode_legal = 1'b1;
         default:                                                  opcode_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_FETCH;
         op_q       <= '0;
         wait_cnt_q <= '0;
         fault_q    <= '0;
         instret_q  <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         wait_cnt_q <= wait_cnt_d;
         fault_q    <= fault_d;
         if (pc_we_o) instret_q <= instret_q + CNT_W'(1);
      end
   end

   // wait_cnt defaults to zero so it clears on every transition and outside memory states.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      wait_cnt_d = '0;
      fault_d    = fault_q;
      case (state_q)
         ST_FETCH: begin
            if (mem_ready_i) begin
               state_d = ST_DECODE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d = ST_TRAP;
               fault_d = 2'd2;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         ST_DECODE: begin
            op_d = opcode_i;
            if (opcode_legal) begin
               state_d = ST_EXEC;
            end else begin
               state_d = ST_TRAP;
               fault_d = 2'd1;
            end
         end
         ST_EXEC: begin
            case (op_q)
               OP_R, OP_I:              state_d = ST_WB;
               OP_LOAD, OP_STORE:       state_d = ST_MEM;
               OP_BRANCH, OP_JAL, OP_LUI: state_d = ST_FETCH;
               default: begin
                  state_d = ST_TRAP;
                  fault_d = 2'd1;
               end
            endcase
         end
         ST_MEM: begin
            if (mem_ready_i) begin
               state_d = (op_q == OP_STORE) ? ST_FETCH : ST_WB;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d = ST_TRAP;
               fault_d = 2'd3;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         ST_WB:   state_d = ST_FETCH;
         ST_TRAP: state_d = ST_TRAP;
         default: begin
            state_d = ST_TRAP;
            fault_d = 2'd1;
         end
      endcase
   end

   always_comb begin
      imem_req_o  = 1'b0;
      ir_we_o     = 1'b0;
      pc_we_o     = 1'b0;
      pc_sel_o    = 1'b0;
      dmem_req_o  = 1'b0;
      dmem_we_o   = 1'b0;
      reg_write_o = 1'b0;
      wb_sel_o    = 2'd0;
      alu_src_o   = 1'b0;
      alu_op_o    = 2'd0;
      if (rst) begin
         case (state_q)
            ST_FETCH: begin
               imem_req_o = 1'b1;
               ir_we_o    = mem_ready_i;
            end
            ST_EXEC: begin
               alu_src_o = !(op_q == OP_R || op_q == OP_BRANCH);
               case (op_q)
                  OP_R, OP_I: alu_op_o = 2'd1;
                  OP_BRANCH: begin
                     alu_op_o = 2'd2;
                     pc_we_o  = 1'b1;
                     pc_sel_o = branch_taken_i;
                  end
                  OP_JAL: begin
                     reg_write_o = 1'b1;
                     wb_sel_o    = 2'd2;
                     pc_we_o     = 1'b1;
                     pc_sel_o    = 1'b1;
                  end
                  OP_LUI: begin
                     reg_write_o = 1'b1;
                     wb_sel_o    = 2'd3;
                     pc_we_o     = 1'b1;
                  end
                  default: alu_op_o = 2'd0;
               endcase
            end
            ST_MEM: begin
               dmem_req_o = 1'b1;
               dmem_we_o  = (op_q == OP_STORE);
               alu_src_o  = 1'b1;
               pc_we_o    = mem_ready_i && (op_q == OP_STORE);
            end
            ST_WB: begin
               reg_write_o = 1'b1;
               pc_we_o     = 1'b1;
               if (op_q == OP_LOAD) begin
                  wb_sel_o  = 2'd1;
                  alu_src_o = 1'b1;
               end else begin
                  alu_op_o  = 2'd1;
                  alu_src_o = (op_q == OP_I);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
module tb_rv_multicycle_ctrl;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BAD    = 7'b0000000;

   localparam logic [11:0] SB_NONE    = 12'h000;
   localparam logic [11:0] SB_FW      = 12'h800;
   localparam logic [11:0] SB_FR      = 12'hC00;
   localparam logic [11:0] SB_EX_R    = 12'h001;
   localparam logic [11:0] SB_EX_I    = 12'h005;
   localparam logic [11:0] SB_EX_M    = 12'h004;
   localparam logic [11:0] SB_EX_BT   = 12'h302;
   localparam logic [11:0] SB_EX_BN   = 12'h202;
   localparam logic [11:0] SB_EX_JAL  = 12'h334;
   localparam logic [11:0] SB_EX_LUI  = 12'h23C;
   localparam logic [11:0] SB_MEM_LD  = 12'h084;
   localparam logic [11:0] SB_MEM_ST  = 12'h0C4;
   localparam logic [11:0] SB_MEM_STR = 12'h2C4;
   localparam logic [11:0] SB_WB_R    = 12'h221;
   localparam logic [11:0] SB_WB_I    = 12'h225;
   localparam logic [11:0] SB_WB_LD   = 12'h22C;

   localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;

   localparam int MIN_CHECKS = 60;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  opcode;
   logic        branch_taken;
   logic        mem_ready;
   logic        imem_req, ir_we, pc_we, pc_sel, dmem_req, dmem_we, reg_write, alu_src;
   logic [1:0]  wb_sel, alu_op, fault;
   logic [2:0]  state;
   logic [31:0] instret;

   logic [48:0] exp_q[$];
   string       name_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic        stim_done = 1'b0;

   rv_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .opcode_i       (opcode),
      .branch_taken_i (branch_taken),
      .mem_ready_i    (mem_ready),
      .imem_req_o     (imem_req),
      .ir_we_o        (ir_we),
      .pc_we_o        (pc_we),
      .pc_sel_o       (pc_sel),
      .dmem_req_o     (dmem_req),
      .dmem_we_o      (dmem_we),
      .reg_write_o    (reg_write),
      .wb_sel_o       (wb_sel),
      .alu_src_o      (alu_src),
      .alu_op_o       (alu_op),
      .fault_o        (fault),
      .state_o        (state),
      .instret_o      (instret)
   );

   always #5 clk = ~clk;

   task automatic step(input string nm, input logic r, input logic [6:0] opc, input logic br,
                       input logic mr, input logic [2:0] st, input logic [11:0] sb,
                       input logic [1:0] f, input logic [31:0] ir);
      rst          = r;
      opcode       = opc;
      branch_taken = br;
      mem_ready    = mr;
      exp_q.push_back({st, sb, f, ir});
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_decode(input string nm, input logic [6:0] opc, input logic [31:0] ir);
      step({nm, "_fetch"},  1'b1, opc, 1'b0, 1'b1, S_F, SB_FR,   2'd0, ir);
      step({nm, "_decode"}, 1'b1, opc, 1'b1, 1'b1, S_D, SB_NONE, 2'd0, ir);
   endtask

   initial begin
      logic [48:0] exp_v, act_v;
      string       nm;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {state, imem_req, ir_we, pc_we, pc_sel, dmem_req, dmem_we, reg_write,
                     wb_sel, alu_src, alu_op, fault, instret};
            n_checks++;
            if (act_v !== exp_v) begin
               n_fail++;
               $display("FAIL %s: got state=%0d strobes=%h fault=%0d instret=%0d, expected state=%0d strobes=%h fault=%0d instret=%0d",
                        nm, act_v[48:46], act_v[45:34], act_v[33:32], act_v[31:0],
                        exp_v[48:46], exp_v[45:34], exp_v[33:32], exp_v[31:0]);
            end else begin
               $display("ok   %s: state=%0d strobes=%h fault=%0d instret=%0d",
                        nm, act_v[48:46], act_v[45:34], act_v[33:32], act_v[31:0]);
            end
         end else if (stim_done) begin
            if (n_checks < MIN_CHECKS) begin
               n_fail++;
               $display("FAIL summary: only %0d cycles checked, expected at least %0d", n_checks, MIN_CHECKS);
            end
            if (name_q.size() != exp_q.size()) begin
               n_fail++;
               $display("FAIL summary: name queue %0d entries vs expectation queue %0d entries",
                        name_q.size(), exp_q.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; opcode = '0; branch_taken = 1'b0; mem_ready = 1'b1;
      @(posedge clk);
      #1;
      step("reset", 1'b0, OP_R, 1'b1, 1'b1, S_F, SB_NONE, 2'd0, 32'd0);

      fetch_decode("add", OP_R, 32'd0);
      step("add_exec", 1'b1, OP_R, 1'b0, 1'b1, S_E, SB_EX_R, 2'd0, 32'd0);
      step("add_wb",   1'b1, OP_R, 1'b0, 1'b1, S_W, SB_WB_R, 2'd0, 32'd0);

      fetch_decode("lw", OP_LOAD, 32'd1);
      step("lw_exec", 1'b1, OP_LOAD, 1'b0, 1'b1, S_E, SB_EX_M, 2'd0, 32'd1);
      for (int i = 0; i < 3; i++)
         step($sformatf("lw_mem_wait%0d", i), 1'b1, OP_LOAD, 1'b0, 1'b0, S_M, SB_MEM_LD, 2'd0, 32'd1);
      step("lw_mem_ready", 1'b1, OP_LOAD, 1'b0, 1'b1, S_M, SB_MEM_LD, 2'd0, 32'd1);
      step("lw_wb",        1'b1, OP_LOAD, 1'b0, 1'b1, S_W, SB_WB_LD,  2'd0, 32'd1);

      fetch_decode("beq_t", OP_BRANCH, 32'd2);
      step("beq_t_exec", 1'b1, OP_BRANCH, 1'b1, 1'b1, S_E, SB_EX_BT, 2'd0, 32'd2);
      fetch_decode("beq_n", OP_BRANCH, 32'd3);
      step("beq_n_exec", 1'b1, OP_BRANCH, 1'b0, 1'b1, S_E, SB_EX_BN, 2'd0, 32'd3);

      fetch_decode("addi", OP_I, 32'd4);
      step("addi_exec", 1'b1, OP_I, 1'b0, 1'b1, S_E, SB_EX_I, 2'd0, 32'd4);
      step("addi_wb",   1'b1, OP_I, 1'b0, 1'b1, S_W, SB_WB_I, 2'd0, 32'd4);

      fetch_decode("jal", OP_JAL, 32'd5);
      step("jal_exec", 1'b1, OP_JAL, 1'b0, 1'b1, S_E, SB_EX_JAL, 2'd0, 32'd5);
      fetch_decode("lui", OP_LUI, 32'd6);
      step("lui_exec", 1'b1, OP_LUI, 1'b1, 1'b1, S_E, SB_EX_LUI, 2'd0, 32'd6);

      fetch_decode("sw", OP_STORE, 32'd7);
      step("sw_exec", 1'b1, OP_STORE, 1'b0, 1'b1, S_E, SB_EX_M,    2'd0, 32'd7);
      step("sw_mem",  1'b1, OP_STORE, 1'b0, 1'b1, S_M, SB_MEM_STR, 2'd0, 32'd7);

      fetch_decode("illegal", OP_BAD, 32'd8);
      for (int i = 0; i < 20; i++)
         step($sformatf("trap_hold%0d", i), 1'b1, OP_R, 1'b1, 1'b1, S_T, SB_NONE, 2'd1, 32'd8);
      step("trap_reset", 1'b0, OP_R, 1'b1, 1'b1, S_T, SB_NONE, 2'd1, 32'd8);

      for (int i = 0; i < 4; i++)
         step($sformatf("ftimeout_wait%0d", i), 1'b1, OP_R, 1'b0, 1'b0, S_F, SB_FW, 2'd0, 32'd0);
      for (int i = 0; i < 3; i++)
         step($sformatf("ftimeout_trap%0d", i), 1'b1, OP_R, 1'b0, 1'b1, S_T, SB_NONE, 2'd2, 32'd0);
      step("ftimeout_reset", 1'b0, OP_R, 1'b0, 1'b1, S_T, SB_NONE, 2'd2, 32'd0);

      fetch_decode("sw_to", OP_STORE, 32'd0);
      step("sw_to_exec", 1'b1, OP_STORE, 1'b0, 1'b0, S_E, SB_EX_M, 2'd0, 32'd0);
      for (int i = 0; i < 4; i++)
         step($sformatf("dtimeout_wait%0d", i), 1'b1, OP_STORE, 1'b0, 1'b0, S_M, SB_MEM_ST, 2'd0, 32'd0);
      for (int i = 0; i < 2; i++)
         step($sformatf("dtimeout_trap%0d", i), 1'b1, OP_STORE, 1'b0, 1'b1, S_T, SB_NONE, 2'd3, 32'd0);
      step("dtimeout_reset", 1'b0, OP_STORE, 1'b0, 1'b1, S_T, SB_NONE, 2'd3, 32'd0);

      fetch_decode("sw_rst", OP_STORE, 32'd0);
      step("sw_rst_exec",    1'b1, OP_STORE, 1'b0, 1'b1, S_E, SB_EX_M, 2'd0, 32'd0);
      step("sw_rst_mem",     1'b0, OP_STORE, 1'b0, 1'b1, S_M, SB_NONE, 2'd0, 32'd0);
      step("sw_rst_after",   1'b1, OP_STORE, 1'b0, 1'b0, S_F, SB_FW,   2'd0, 32'd0);
      step("sw_rst_after2",  1'b1, OP_STORE, 1'b0, 1'b1, S_F, SB_FR,   2'd0, 32'd0);

      stim_done = 1'b1;
   end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Control FSM that sequences the RV32I multicycle datapath: instruction fetch, decode/register read, execute, memory access, register writeback.
- Drives instruction-register and PC write enables, register-file write, memory request strobes, and ALU/writeback mux selects.
- Enforces memory handshake timeouts and traps on unsupported opcodes.
- Counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive wait cycles on a memory request before trapping (1..255).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- opcode  in  7  inst[6:0] from the instruction register.
- branch_taken  in  1  branch compare result from the ALU; valid in EXEC.
- mem_ready  in  1  memory acknowledge; may be asserted combinationally in the same cycle as the request.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  instruction register load.
- pc_we  out  1  PC update (retire strobe).
- pc_sel  out  1  0 = PC+4, 1 = PC+imm32.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (store).
- reg_write  out  1  register file write enable.
- wb_sel  out  2  writeback source: 0 = ALU, 1 = memory, 2 = PC+4, 3 = imm32.
- alu_src  out  1  0 = rs2Data, 1 = imm32.
- alu_op  out  2  0 = add, 1 = funct-decoded, 2 = branch compare.
- fault  out  2  0 = none, 1 = illegal opcode, 2 = fetch timeout, 3 = data timeout.
- state  out  3  current FSM state, for debug.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst=0 at posedge clk): state=FETCH, op_q=0, wait_cnt=0, fault=0, instret=0. All strobes are 0 during any cycle in which rst=0. Reset overrides any in-progress access, including a pending mem_ready.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 are unreachable and go to TRAP with fault=1.
- Output timing: strobes are a combinational function of state, op_q, mem_ready and branch_taken. All registers update on posedge clk.
- FETCH:
  - imem_req=1.
  - If mem_ready=1: ir_we=1, wait_cnt←0, next state DECODE.
  - Otherwise wait_cnt increments. When wait_cnt==MEM_TIMEOUT-1 with mem_ready still 0: fault←2, next state TRAP.
- DECODE:
  - op_q←opcode.
  - Supported opcodes: 0110011 (R), 0010011 (I-ALU), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH), 0110111 (LUI), 1101111 (JAL). These go to EXEC.
  - Any other opcode: fault←1, next state TRAP.
- EXEC (alu_src=1 for all except R and BRANCH):
  - R and I-ALU: alu_op=1, next state WB.
  - LOAD and STORE: alu_op=0, next state MEM.
  - BRANCH: alu_op=2, pc_we=1, pc_sel=branch_taken, next state FETCH.
  - JAL: reg_write=1, wb_sel=2, pc_we=1, pc_sel=1, next state FETCH.
  - LUI: reg_write=1, wb_sel=3, pc_we=1, pc_sel=0, next state FETCH.
- MEM:
  - dmem_req=1, dmem_we=(op_q==STORE). alu_op=0 and alu_src=1 are held so the address stays stable.
  - On mem_ready with STORE: pc_we=1, pc_sel=0, next state FETCH.
  - On mem_ready with LOAD: next state WB.
  - Timeout as in FETCH, with fault←3.
- WB: reg_write=1, wb_sel=(LOAD?1:0), alu_op/alu_src held from EXEC, pc_we=1, pc_sel=0, next state FETCH.
- TRAP: all strobes 0. State and fault are sticky until reset.
- instret increments by 1 on every cycle with pc_we=1, and wraps modulo 2^CNT_W.
- wait_cnt is cleared on every state transition. It is never set beyond MEM_TIMEOUT-1.
- Latency with zero-wait memory: BRANCH, JAL and LUI take 3 cycles; R, I-ALU and STORE take 4; LOAD takes 5.

Test Plan:
- Reset then ADD (0110011), mem_ready tied 1 → states 0,1,2,4 → FETCH. reg_write=1 with wb_sel=0 in cycle 4. pc_we pulses once. instret=1.
- LW (0000011), dmem mem_ready delayed 3 cycles → MEM held 4 cycles with dmem_req=1 and dmem_we=0. WB asserts wb_sel=1. Total 8 cycles.
- BEQ with branch_taken=1, then BEQ with branch_taken=0 → pc_sel=1 then pc_sel=0, each in the 3rd cycle. reg_write never asserted. instret=2.
- Opcode 0000000 → TRAP after DECODE with fault=1. Strobes stay 0 for 20 cycles. rst=0 for 1 cycle returns to FETCH with fault=0 and instret=0.
- MEM_TIMEOUT=4 and mem_ready held 0 during FETCH → TRAP after exactly 4 FETCH cycles with fault=2. Same test on a STORE in MEM → fault=3.
- rst driven low in MEM with mem_ready=1 → no pc_we and no instret increment. Next state is FETCH.
